// File: rtl/decode_stage_if.sv
// Fetch/execute-facing bundle of the decode stage.
// The driver (fetch + execute side) uses master; the decode stage uses slave.
interface decode_stage_if #(
   parameter int XLEN = 32
);
   logic            i_Flush;
   logic            i_InstrValid;
   logic            o_InstrReady;
   logic [31:0]     i_InstructionWord;
   logic [XLEN-1:0] i_PC;
   logic            o_Valid;
   logic            i_Ready;
   logic [XLEN-1:0] o_PC;
   logic [4:0]      o_Opcode;
   logic [2:0]      o_Funct3;
   logic [6:0]      o_Funct7;
   logic [4:0]      o_rd;
   logic [4:0]      o_rs1;
   logic [4:0]      o_rs2;
   logic [XLEN-1:0] o_ImmediateData;
   logic [13:0]     o_Ctrl;
   logic [1:0]      o_MemAlignment;
   logic            o_IllegalInstruction;

   modport master (
      output i_Flush, i_InstrValid, i_InstructionWord, i_PC, i_Ready,
      input  o_InstrReady, o_Valid, o_PC, o_Opcode, o_Funct3, o_Funct7,
      input  o_rd, o_rs1, o_rs2, o_ImmediateData, o_Ctrl,
      input  o_MemAlignment, o_IllegalInstruction
   );

   modport slave (
      input  i_Flush, i_InstrValid, i_InstructionWord, i_PC, i_Ready,
      output o_InstrReady, o_Valid, o_PC, o_Opcode, o_Funct3, o_Funct7,
      output o_rd, o_rs1, o_rs2, o_ImmediateData, o_Ctrl,
      output o_MemAlignment, o_IllegalInstruction
   );
endinterface

// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: combinational decode captured into a
// two-entry skid buffer with valid/ready on both sides and sync flush.
module decode_stage #(
   parameter int XLEN = 32
) (
   input  logic          i_Clock,
   input  logic          i_Reset_n,
   decode_stage_if.slave bus
);
   localparam bit RV64 = (XLEN == 64);

   localparam logic [4:0] OPC_LOAD      = 5'b00000;
   localparam logic [4:0] OPC_MISC_MEM  = 5'b00011;
   localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
   localparam logic [4:0] OPC_AUIPC     = 5'b00101;
   localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
   localparam logic [4:0] OPC_STORE     = 5'b01000;
   localparam logic [4:0] OPC_OP        = 5'b01100;
   localparam logic [4:0] OPC_LUI       = 5'b01101;
   localparam logic [4:0] OPC_OP_32     = 5'b01110;
   localparam logic [4:0] OPC_BRANCH    = 5'b11000;
   localparam logic [4:0] OPC_JALR      = 5'b11001;
   localparam logic [4:0] OPC_JAL       = 5'b11011;
   localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

   typedef enum logic [1:0] {
      S_EMPTY,
      S_ONE,
      S_FULL
   } state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [4:0]      opcode;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [XLEN-1:0] imm;
      logic [13:0]     ctrl;
      logic [1:0]      align;
      logic            illegal;
   } dec_t;

   logic [31:0] w;
   logic [4:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;

   logic is_load, is_store, is_branch, is_jal, is_jalr;
   logic is_opimm, is_opimm32, is_op, is_op32;
   logic is_lui, is_auipc, is_fence, is_system;
   logic is_ecall, is_ebreak;
   logic ill;
   logic [31:0] imm32;
   logic [13:0] ctrl;
   dec_t        dec;

   state_e state_q, state_d;
   logic   rdy_q, rdy_d;
   dec_t   out_q, out_d;
   dec_t   skid_q, skid_d;
   logic   in_xfer, out_xfer;

   assign w   = bus.i_InstructionWord;
   assign opc = w[6:2];
   assign f3  = w[14:12];
   assign f7  = w[31:25];

   always_comb begin
      is_load    = (opc == OPC_LOAD);
      is_store   = (opc == OPC_STORE);
      is_branch  = (opc == OPC_BRANCH);
      is_jal     = (opc == OPC_JAL);
      is_jalr    = (opc == OPC_JALR);
      is_opimm   = (opc == OPC_OP_IMM);
      is_opimm32 = (opc == OPC_OP_IMM_32);
      is_op      = (opc == OPC_OP);
      is_op32    = (opc == OPC_OP_32);
      is_lui     = (opc == OPC_LUI);
      is_auipc   = (opc == OPC_AUIPC);
      is_fence   = (opc == OPC_MISC_MEM);
      is_system  = (opc == OPC_SYSTEM);
      is_ecall   = is_system && (w[31:7] == 25'd0);
      is_ebreak  = is_system && (w[31:20] == 12'd1)
                 && (w[19:7] == 13'd0);
   end

   // Anything outside the recognised opcode set (FP, AMO, custom,
   // reserved, long encodings) falls through as illegal.
   always_comb begin
      ill = (w[1:0] != 2'b11);
      ill = ill || !(is_load || is_store || is_branch || is_jal
                  || is_jalr || is_opimm || is_opimm32 || is_op
                  || is_op32 || is_lui || is_auipc || is_fence
                  || is_system);
      if (is_load)
         ill = ill || (f3 == 3'b111)
             || (!RV64 && (f3 == 3'b011 || f3 == 3'b110));
      if (is_store)
         ill = ill || f3[2] || (!RV64 && f3 == 3'b011);
      if (is_branch)
         ill = ill || (f3 == 3'b010) || (f3 == 3'b011);
      if (is_jalr)
         ill = ill || (f3 != 3'b000);
      if (is_opimm)
         ill = ill || (!RV64 && w[25]
             && (f3 == 3'b001 || f3 == 3'b101));
      if (is_opimm32 || is_op32)
         ill = ill || !RV64;
      if (is_op)
         ill = ill || !((f7 == 7'b0000000)
             || (f7 == 7'b0100000
                 && (f3 == 3'b000 || f3 == 3'b101)));
      if (is_system)
         ill = ill || !(is_ecall || is_ebreak);
   end

   always_comb begin
      imm32 = 32'd0;
      unique case (1'b1)
         is_load, is_opimm, is_opimm32, is_jalr, is_system:
            imm32 = {{20{w[31]}}, w[31:20]};
         is_store:
            imm32 = {{20{w[31]}}, w[31:25], w[11:7]};
         is_branch:
            imm32 = {{19{w[31]}}, w[31], w[7],
                     w[30:25], w[11:8], 1'b0};
         is_lui, is_auipc:
            imm32 = {w[31:12], 12'd0};
         is_jal:
            imm32 = {{11{w[31]}}, w[31], w[19:12],
                     w[20], w[30:21], 1'b0};
         default:
            imm32 = 32'd0;
      endcase
   end

   always_comb begin
      ctrl = {
         is_op || is_opimm || is_op32 || is_opimm32,
         is_opimm || is_opimm32,
         is_op32 || is_opimm32,
         is_lui,
         is_auipc,
         is_jal,
         is_jalr,
         is_branch,
         is_load,
         is_store,
         is_load && f3[2],
         is_fence,
         is_ecall,
         is_ebreak
      };
      if (ill)
         ctrl = 14'd0;
   end

   always_comb begin
      dec.pc      = bus.i_PC;
      dec.opcode  = opc;
      dec.funct3  = f3;
      dec.funct7  = f7;
      dec.rd      = w[11:7];
      dec.rs1     = w[19:15];
      dec.rs2     = w[24:20];
      dec.imm     = XLEN'(signed'(imm32));
      dec.ctrl    = ctrl;
      dec.align   = (is_load || is_store) ? f3[1:0] : 2'b00;
      dec.illegal = ill;
   end

   assign in_xfer  = bus.i_InstrValid && rdy_q && !bus.i_Flush;
   assign out_xfer = (state_q != S_EMPTY) && bus.i_Ready;

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      unique case (state_q)
         S_EMPTY: begin
            if (in_xfer) begin
               out_d   = dec;
               state_d = S_ONE;
            end
         end
         S_ONE: begin
            if (in_xfer && out_xfer) begin
               out_d = dec;
            end else if (in_xfer) begin
               skid_d  = dec;
               state_d = S_FULL;
            end else if (out_xfer) begin
               state_d = S_EMPTY;
            end
         end
         S_FULL: begin
            if (out_xfer) begin
               out_d   = skid_q;
               state_d = S_ONE;
            end
         end
         default: state_d = S_EMPTY;
      endcase
      if (bus.i_Flush)
         state_d = S_EMPTY;
      // Ready is registered so it never depends on i_Ready this cycle.
      rdy_d = (state_d != S_FULL);
   end

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q <= S_EMPTY;
         rdy_q   <= 1'b1;
         out_q   <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         rdy_q   <= rdy_d;
         out_q   <= out_d;
         skid_q  <= skid_d;
      end
   end

   assign bus.o_Valid              = (state_q != S_EMPTY);
   assign bus.o_InstrReady         = rdy_q;
   assign bus.o_PC                 = out_q.pc;
   assign bus.o_Opcode             = out_q.opcode;
   assign bus.o_Funct3             = out_q.funct3;
   assign bus.o_Funct7             = out_q.funct7;
   assign bus.o_rd                 = out_q.rd;
   assign bus.o_rs1                = out_q.rs1;
   assign bus.o_rs2                = out_q.rs2;
   assign bus.o_ImmediateData      = out_q.imm;
   assign bus.o_Ctrl               = out_q.ctrl;
   assign bus.o_MemAlignment       = out_q.align;
   assign bus.o_IllegalInstruction = out_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage, one RV32 and one RV64 instance
// fed the same instruction stream.
module tb_decode_stage;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   decode_stage_if #(.XLEN(32)) if32 ();
   decode_stage_if #(.XLEN(64)) if64 ();

   decode_stage #(.XLEN(32)) u32 (
      .i_Clock   (clk),
      .i_Reset_n (rst_n),
      .bus       (if32)
   );

   decode_stage #(.XLEN(64)) u64 (
      .i_Clock   (clk),
      .i_Reset_n (rst_n),
      .bus       (if64)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] w,
                        input logic [63:0] pc);
      if32.i_InstrValid      = v;
      if32.i_InstructionWord = w;
      if32.i_PC              = pc[31:0];
      if64.i_InstrValid      = v;
      if64.i_InstructionWord = w;
      if64.i_PC              = pc;
   endtask

   task automatic rdy(input logic r);
      if32.i_Ready = r;
      if64.i_Ready = r;
   endtask

   task automatic flush(input logic f);
      if32.i_Flush = f;
      if64.i_Flush = f;
   endtask

   task automatic send(input logic [31:0] w, input logic [63:0] pc);
      drive(1'b1, w, pc);
      @(negedge clk);
      drive(1'b0, 32'd0, 64'd0);
   endtask

   initial begin
      flush(1'b0);
      rdy(1'b1);
      drive(1'b0, 32'd0, 64'd0);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_valid32", 64'(if32.o_Valid), 64'd0);
      chk("rst_ready32", 64'(if32.o_InstrReady), 64'd1);
      chk("rst_imm64", if64.o_ImmediateData, 64'd0);
      chk("rst_ill32", 64'(if32.o_IllegalInstruction), 64'd0);
      chk("rst_ctrl64", 64'(if64.o_Ctrl), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ADDI x1,x2,-5
      send(32'hFFB10093, 64'h100);
      chk("addi_valid", 64'(if32.o_Valid), 64'd1);
      chk("addi_imm", 64'(if32.o_ImmediateData), 64'hFFFFFFFB);
      chk("addi_ctrl", 64'(if32.o_Ctrl), 64'h3000);
      chk("addi_rd", 64'(if32.o_rd), 64'd1);
      chk("addi_rs1", 64'(if32.o_rs1), 64'd2);
      chk("addi_ill", 64'(if32.o_IllegalInstruction), 64'd0);
      chk("addi_pc", 64'(if32.o_PC), 64'h100);
      chk("addi_opc", 64'(if32.o_Opcode), 64'h04);

      // JAL x0,-2048
      send(32'h801FF06F, 64'h200);
      chk("jal_imm64", if64.o_ImmediateData, 64'hFFFFFFFFFFFFF800);
      chk("jal_ctrl", 64'(if64.o_Ctrl), 64'h0100);
      // imm[20]=1, imm[11]=1, rest zero
      send(32'h8010006F, 64'h204);
      chk("jal2_imm64", if64.o_ImmediateData, 64'hFFFFFFFFFFF00800);
      chk("jal2_imm32", 64'(if32.o_ImmediateData), 64'hFFF00800);

      // LUI x5,0x80000
      send(32'h800002B7, 64'h208);
      chk("lui_imm64", if64.o_ImmediateData, 64'hFFFFFFFF80000000);
      chk("lui_imm32", 64'(if32.o_ImmediateData), 64'h80000000);
      chk("lui_rd", 64'(if64.o_rd), 64'd5);
      chk("lui_ctrl", 64'(if64.o_Ctrl), 64'h0400);

      // SW x3,8(x4)
      send(32'h00322423, 64'h20C);
      chk("sw_imm64", if64.o_ImmediateData, 64'd8);
      chk("sw_ctrl", 64'(if64.o_Ctrl), 64'h0010);
      chk("sw_align", 64'(if64.o_MemAlignment), 64'd2);
      chk("sw_rs1", 64'(if64.o_rs1), 64'd4);
      chk("sw_rs2", 64'(if64.o_rs2), 64'd3);

      // LD x1,0(x2)
      send(32'h00013083, 64'h210);
      chk("ld_ill32", 64'(if32.o_IllegalInstruction), 64'd1);
      chk("ld_ctrl32", 64'(if32.o_Ctrl), 64'd0);
      chk("ld_valid32", 64'(if32.o_Valid), 64'd1);
      chk("ld_ill64", 64'(if64.o_IllegalInstruction), 64'd0);
      chk("ld_ctrl64", 64'(if64.o_Ctrl), 64'h0020);
      chk("ld_align64", 64'(if64.o_MemAlignment), 64'd3);

      send(32'h00000010, 64'h214);
      chk("lowbits_ill", 64'(if32.o_IllegalInstruction), 64'd1);

      // SLLI x1,x1,32
      send(32'h02009093, 64'h218);
      chk("slli_ill32", 64'(if32.o_IllegalInstruction), 64'd1);
      chk("slli_ill64", 64'(if64.o_IllegalInstruction), 64'd0);
      chk("slli_imm64", if64.o_ImmediateData, 64'h20);

      // BEQ x0,x0,-4
      send(32'hFE000EE3, 64'h21C);
      chk("beq_imm", 64'(if32.o_ImmediateData), 64'hFFFFFFFC);
      chk("beq_ctrl", 64'(if32.o_Ctrl), 64'h0040);

      send(32'h40000033, 64'h220);
      chk("sub_ill", 64'(if32.o_IllegalInstruction), 64'd0);
      chk("sub_ctrl", 64'(if32.o_Ctrl), 64'h2000);
      send(32'h40001033, 64'h224);
      chk("sllf7_ill", 64'(if32.o_IllegalInstruction), 64'd1);

      send(32'h00000073, 64'h228);
      chk("ecall_ctrl", 64'(if32.o_Ctrl), 64'h0002);
      send(32'h00100073, 64'h22C);
      chk("ebreak_ctrl", 64'(if64.o_Ctrl), 64'h0001);
      send(32'h34011073, 64'h230);
      chk("csr_ill", 64'(if64.o_IllegalInstruction), 64'd1);

      @(negedge clk);
      chk("drain_valid", 64'(if32.o_Valid), 64'd0);

      // back-pressure: offer four, expect two accepted
      rdy(1'b0);
      for (int k = 1; k <= 4; k++) begin
         drive(1'b1, (32'(k) << 20) | 32'h93, 64'h1000 + 64'(4 * k));
         chk("bp_rdy", 64'(if32.o_InstrReady), (k <= 2) ? 64'd1 : 64'd0);
         @(negedge clk);
      end
      drive(1'b0, 32'd0, 64'd0);
      chk("bp_full_rdy", 64'(if32.o_InstrReady), 64'd0);
      chk("bp_valid", 64'(if32.o_Valid), 64'd1);
      chk("bp_pc1", 64'(if32.o_PC), 64'h1004);
      chk("bp_imm1", 64'(if32.o_ImmediateData), 64'd1);
      chk("bp_pc1_64", if64.o_PC, 64'h1004);
      rdy(1'b1);
      @(negedge clk);
      chk("bp_pc2", 64'(if32.o_PC), 64'h1008);
      chk("bp_imm2", 64'(if32.o_ImmediateData), 64'd2);
      chk("bp_valid2", 64'(if32.o_Valid), 64'd1);
      chk("bp_rdy2", 64'(if32.o_InstrReady), 64'd1);
      @(negedge clk);
      chk("bp_empty", 64'(if32.o_Valid), 64'd0);

      // flush while full with a new word offered
      rdy(1'b0);
      send(32'h00100093, 64'h2000);
      send(32'h00200093, 64'h2004);
      chk("fl_full", 64'(if32.o_InstrReady), 64'd0);
      drive(1'b1, 32'h00300093, 64'h2008);
      flush(1'b1);
      @(negedge clk);
      flush(1'b0);
      drive(1'b0, 32'd0, 64'd0);
      chk("fl_valid", 64'(if32.o_Valid), 64'd0);
      chk("fl_rdy", 64'(if32.o_InstrReady), 64'd1);
      chk("fl_valid64", 64'(if64.o_Valid), 64'd0);
      rdy(1'b1);
      @(negedge clk);
      chk("fl_gone", 64'(if32.o_Valid), 64'd0);

      // asynchronous reset while full
      rdy(1'b0);
      send(32'hFFB10093, 64'h3000);
      send(32'h800002B7, 64'h3004);
      chk("ar_pre", 64'(if64.o_Valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid", 64'(if64.o_Valid), 64'd0);
      chk("ar_imm", if64.o_ImmediateData, 64'd0);
      chk("ar_pc", if64.o_PC, 64'd0);
      chk("ar_rdy", 64'(if32.o_InstrReady), 64'd1);
      chk("ar_ctrl", 64'(if32.o_Ctrl), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send(32'hFFB10093, 64'h4000);
      chk("post_imm", 64'(if32.o_ImmediateData), 64'hFFFFFFFB);
      chk("post_pc", 64'(if32.o_PC), 64'h4000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
